input_deserializer: RTL and testbench

Input-side counterpart of the systolic output path. It accepts a stream of 64-bit words from the upstream source over a valid/ready handshake and packs WORDS consecutive words into one 512-bit operand frame. It presents each frame to the systolic array loader over a second valid/ready handshake. It sits between the host/memory word interface and the systolic array input buffer.

---
 rtl/input_deserializer.sv | 88 ++++++++
 tb/tb_input_deserializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/input_deserializer.sv
// Packs WORDS consecutive IN_WIDTH-bit source words into one OUT_WIDTH-bit frame
// and hands each frame to the systolic loader over a valid/ready handshake.
module input_deserializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 512,
  localparam int WORDS     = OUT_WIDTH / IN_WIDTH,
  localparam int CNT_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_valid,
  input  logic [IN_WIDTH-1:0]  src_data,
  output logic                 src_ready,
  input  logic                 flush,
  input  logic                 dest_ready,
  output logic                 dest_valid,
  output logic [OUT_WIDTH-1:0] systolic_input,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 rx_done,
  output logic                 pack_done
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   accept;
  logic                   last;
  logic [CNT_WIDTH-1:0]   count_p1;
  logic [OUT_WIDTH-1:0]   lanes_p1;
  logic                   rx_done_p1;
  logic                   pack_done_p1;

  // src_ready is deliberately independent of src_valid so upstream can wait on it.
  assign src_ready = (state == FILL) && !flush;
  assign accept    = src_valid && src_ready;
  assign last      = (count_p1 == CNT_WIDTH'(WORDS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && last) state_nxt = FULL;
      FULL: if (flush || dest_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // Stage p1: lane counter and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p1     <= '0;
      rx_done_p1   <= 1'b0;
      pack_done_p1 <= 1'b0;
    end else begin
      rx_done_p1   <= accept;
      pack_done_p1 <= accept && last;
      if (flush)       count_p1 <= '0;
      else if (accept) count_p1 <= last ? '0 : count_p1 + 1'b1;
    end
  end

  // Stage p1: lane storage; lanes are overwritten in place, never cleared between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_p1 <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (accept && (count_p1 == CNT_WIDTH'(i)))
          lanes_p1[i*IN_WIDTH +: IN_WIDTH] <= src_data;
      end
    end
  end

  assign dest_valid     = (state == FULL);
  assign systolic_input = lanes_p1;
  assign word_count     = count_p1;
  assign rx_done        = rx_done_p1;
  assign pack_done      = pack_done_p1;

endmodule

// File: tb/tb_input_deserializer.sv
// Scoreboard bench for input_deserializer: a word-queue model predicts frames and
// handshake outputs; a negedge monitor compares whatever the DUT presents.
module tb_input_deserializer;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int NW = OW / IW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          src_valid = 1'b0;
  logic [IW-1:0] src_data = '0;
  logic          src_ready;
  logic          flush = 1'b0;
  logic          dest_ready = 1'b0;
  logic          dest_valid;
  logic [OW-1:0] systolic_input;
  logic [2:0]    word_count;
  logic          rx_done;
  logic          pack_done;

  input_deserializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .flush(flush), .dest_ready(dest_ready),
    .dest_valid(dest_valid), .systolic_input(systolic_input),
    .word_count(word_count), .rx_done(rx_done), .pack_done(pack_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words received so far in the current frame, and whether a frame waits.
  logic [IW-1:0] m_words[$];
  bit            m_full = 0;
  logic [OW-1:0] sb[$];
  int            frames_out = 0;

  bit pend_dv = 0, pend_rx = 0, pend_pack = 0, pend_zero = 0;
  int pend_cnt = 0;
  bit cur_dv = 0, cur_rx = 0, cur_pack = 0, cur_zero = 0;
  int cur_cnt = 0;
  bit seen_reset = 0, armed = 0;

  task automatic cycle(input bit v, input logic [IW-1:0] d, input bit dr, input bit fl, input bit rs);
    bit acc;
    logic [OW-1:0] frame;
    @(posedge clk);
    cur_dv = pend_dv; cur_rx = pend_rx; cur_pack = pend_pack;
    cur_cnt = pend_cnt; cur_zero = pend_zero;
    if (seen_reset) armed = 1;
    #1;
    src_valid = v; src_data = d; dest_ready = dr; flush = fl; reset = rs;
    #1;
    chk("src_ready", {511'b0, src_ready}, {511'b0, (!m_full && !fl)});
    acc = v && !m_full && !fl;
    pend_zero = rs;
    pend_rx = 0; pend_pack = 0;
    if (rs) begin
      seen_reset = 1;
      m_words.delete();
      m_full = 0;
    end else begin
      pend_rx = acc;
      if (fl) begin
        m_words.delete();
        m_full = 0;
      end else if (m_full) begin
        if (dr) begin m_full = 0; frames_out++; end
      end else if (acc) begin
        m_words.push_back(d);
        if (m_words.size() == NW) begin
          frame = '0;
          for (int i = 0; i < NW; i++) frame[i*IW +: IW] = m_words[i];
          sb.push_back(frame);
          m_words.delete();
          m_full = 1;
          pend_pack = 1;
        end
      end
    end
    pend_dv = m_full;
    pend_cnt = m_words.size();
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) cycle(0, 64'hdead_beef_0bad_f00d, dr, 0, 0);
  endtask

  task automatic send_frame(input logic [IW-1:0] base, input bit dr);
    for (int i = 0; i < NW; i++) cycle(1, base + IW'(i), dr, 0, 0);
  endtask

  logic [OW-1:0] held = '0;

  always @(negedge clk) begin
    if (armed) begin
      chk("dest_valid", {511'b0, dest_valid}, {511'b0, cur_dv});
      chk("rx_done", {511'b0, rx_done}, {511'b0, cur_rx});
      chk("pack_done", {511'b0, pack_done}, {511'b0, cur_pack});
      chk("word_count", {509'b0, word_count}, OW'(cur_cnt));
      if (cur_zero) chk("sys_after_reset", systolic_input, '0);
      if (pack_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_pop: pack_done with empty scoreboard at %0t", $time);
        end else begin
          held = sb.pop_front();
          chk("frame", systolic_input, held);
        end
      end else if (dest_valid) begin
        chk("frame_hold", systolic_input, held);
      end
    end
  end

  initial begin
    // 1: reset then back-to-back words 1..8 with dest_ready high
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 1);
    send_frame(64'd1, 1);
    idle(3, 1);
    // 2: frame held while src_valid keeps presenting new data
    send_frame(64'h100, 0);
    for (int i = 0; i < 5; i++) cycle(1, 64'($urandom), 0, 0, 0);
    cycle(1, 64'h5555, 1, 0, 0);
    send_frame(64'h200, 1);
    idle(2, 1);
    // 3: random 1-3 cycle gaps between words
    for (int i = 0; i < NW; i++) begin
      cycle(1, 64'd1 + IW'(i), 1, 0, 0);
      idle($urandom_range(1, 3), 1);
    end
    idle(2, 1);
    // 4: flush after 5 words with src_valid high
    for (int i = 0; i < 5; i++) cycle(1, 64'hf000 + IW'(i), 1, 0, 0);
    cycle(1, 64'hbad, 1, 1, 0);
    send_frame(64'h300, 1);
    idle(2, 1);
    // 5: flush and dest_ready together while full
    send_frame(64'h400, 0);
    cycle(0, '0, 1, 1, 0);
    idle(2, 0);
    // 6: reset after 3 words, then a fresh frame
    for (int i = 0; i < 3; i++) cycle(1, 64'h500 + IW'(i), 0, 0, 0);
    cycle(1, 64'h5ff, 0, 0, 1);
    send_frame(64'h600, 0);
    idle(2, 1);
    // random traffic
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
    idle(4, 1);
    chk("scoreboard_empty", OW'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
